// File: rtl/dataflow_model.sv
// Autonomous serial pattern generator: emits PATTERN[PLEN-1:0] LSB first on y,
// one bit per clock, repeating forever. The only state is the index register.
module dataflow_model #(
  parameter int unsigned PLEN    = 8,
  parameter logic [15:0] PATTERN = 16'h00D2
) (
  input  logic clk,
  input  logic reset,
  output logic y
);

  if (PLEN < 2 || PLEN > 16) begin : g_bad_plen
    $error("dataflow_model: PLEN must be in 2..16");
  end

  localparam logic [3:0] LAST_IDX  = 4'(PLEN - 1);
  localparam logic [4:0] PLEN_W    = 5'(PLEN);

  logic [3:0] idx_q;
  logic [3:0] idx_d;
  logic       in_range;
  logic       at_last;

  // Out-of-range indices (only possible before the first reset) fold back to 0
  // on the next edge and decode as 0 meanwhile.
  always_comb begin
    in_range = ({1'b0, idx_q} < PLEN_W);
    at_last  = (idx_q == LAST_IDX);
    idx_d    = idx_q + 4'd1;
    if (at_last || !in_range) begin
      idx_d = '0;
    end
  end

  always_comb begin
    y = 1'b0;
    if (in_range) begin
      y = PATTERN[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: tb/tb_dataflow_model.sv
// Bench for dataflow_model: four parameterisations share clk/reset and are
// checked against a cycle-position model plus fixed expected-sequence tables.
module tb_dataflow_model;

  logic       clk;
  logic       reset;
  logic [3:0] ys;

  int n_checks;
  int n_fails;

  int unsigned   plen [4];
  logic [15:0]   pat  [4];
  int unsigned   pos  [4];
  string         nm   [4];

  dataflow_model u_def (
    .clk   (clk),
    .reset (reset),
    .y     (ys[0])
  );

  dataflow_model #(.PLEN(3), .PATTERN(16'h0006)) u_p3 (
    .clk   (clk),
    .reset (reset),
    .y     (ys[1])
  );

  dataflow_model #(.PLEN(2), .PATTERN(16'hFFFE)) u_p2 (
    .clk   (clk),
    .reset (reset),
    .y     (ys[2])
  );

  dataflow_model #(.PLEN(16), .PATTERN(16'hA5C3)) u_p16 (
    .clk   (clk),
    .reset (reset),
    .y     (ys[3])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge; the model advances each instance's position modulo its length.
  task automatic step(input logic r);
    reset = r;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (r) pos[k] = 0;
      else   pos[k] = (pos[k] + 1) % plen[k];
      check(nm[k], ys[k], pat[k][pos[k]]);
    end
  endtask

  typedef struct {
    logic rst;
    logic exp_def;
    logic exp_p3;
    logic exp_p2;
  } vec_t;

  vec_t tbl [14];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    plen = '{8, 3, 2, 16};
    pat  = '{16'h00D2, 16'h0006, 16'hFFFE, 16'hA5C3};
    pos  = '{0, 0, 0, 0};
    nm   = '{"model_def", "model_p3", "model_p2", "model_p16"};

    // reset, then default 0,1,0,0,1,0,1,1 | 0,1 ; p3 0,1,1,0,... ; p2 0,1,0,...
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst);
      check("tbl_def", ys[0], tbl[i].exp_def);
      check("tbl_p3",  ys[1], tbl[i].exp_p3);
      check("tbl_p2",  ys[2], tbl[i].exp_p2);
    end

    // Mid-sequence reset at index 5 of the default pattern.
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    check("mid_idx5_y", ys[0], 1'b0);
    step(1'b1);
    check("mid_rst_y", ys[0], 1'b0);
    step(1'b0);
    check("mid_restart_y", ys[0], 1'b1);

    // Held reset: no advance over four edges.
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      check("held_def", ys[0], 1'b0);
      check("held_p2",  ys[2], 1'b0);
    end

    // Three full default periods: y must repeat with period exactly 8.
    begin
      logic [7:0] first;
      first = '0;
      for (int c = 0; c < 24; c++) begin
        step(1'b0);
        if (c < 8) first[c] = ys[0];
        else check("period8", ys[0], first[c % 8]);
      end
      check("period_word", first[0], 1'b1);
    end

    // Randomized reset activity against the position model.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
